// File: rtl/sdr_app_traffic_gen.sv
// Application-side burst initiator for the SDRAM controller app_* interface:
// writes an incrementing pattern from a seed, reads it back and counts mismatches.
module sdr_app_traffic_gen #(
    parameter int APP_AW  = 26,
    parameter int APP_DW  = 32,
    parameter int APP_BW  = 4,
    parameter int BL      = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr_n,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [BL-1:0]     cmd_len,
    input  logic [APP_DW-1:0] cmd_seed,
    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [BL-1:0]     app_req_len,
    output logic              app_req_wr_n,
    input  logic              app_req_ack,
    output logic [APP_BW-1:0] app_wr_en_n,
    output logic [APP_DW-1:0] app_wr_data,
    input  logic              app_wr_next_req,
    input  logic              app_last_wr,
    input  logic              app_rd_valid,
    input  logic [APP_DW-1:0] app_rd_data,
    input  logic              app_last_rd,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic              proto_err,
    output logic              timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [APP_AW-1:0] addr_nxt;
    logic [BL-1:0]     len_nxt, wcnt, wcnt_nxt, rcnt, rcnt_nxt;
    logic              wr_n_nxt;
    logic [APP_DW-1:0] seed, seed_nxt;
    logic [WD_W-1:0]   wdog, wdog_nxt;
    logic [15:0]       err_nxt;
    logic              proto_nxt, timeout_nxt;
    logic              finish, acked, activity;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_nxt   = state;
        addr_nxt    = app_req_addr;
        len_nxt     = app_req_len;
        wr_n_nxt    = app_req_wr_n;
        seed_nxt    = seed;
        wcnt_nxt    = wcnt;
        rcnt_nxt    = rcnt;
        wdog_nxt    = wdog;
        err_nxt     = err_cnt;
        proto_nxt   = proto_err;
        timeout_nxt = timeout;
        finish      = 1'b0;
        acked       = (state == S_REQ) && app_req_ack;
        activity    = app_wr_next_req || app_rd_valid || acked;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_nxt    = cmd_addr;
                    len_nxt     = cmd_len;
                    wr_n_nxt    = cmd_wr_n;
                    seed_nxt    = cmd_seed;
                    wcnt_nxt    = '0;
                    rcnt_nxt    = '0;
                    wdog_nxt    = '0;
                    err_nxt     = '0;
                    timeout_nxt = 1'b0;
                    // A zero-length burst never reaches the controller.
                    proto_nxt   = (cmd_len == '0);
                    state_nxt   = (cmd_len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ, S_XFER: begin
                if (acked) state_nxt = S_XFER;
                if (!app_req_wr_n) begin
                    if (app_wr_next_req) begin
                        wcnt_nxt = wcnt + BL'(1);
                        finish   = (wcnt_nxt == app_req_len);
                        if (finish != app_last_wr) proto_nxt = 1'b1;
                    end
                    if (app_rd_valid) proto_nxt = 1'b1;
                end else begin
                    if (app_rd_valid) begin
                        if (app_rd_data != seed + APP_DW'(rcnt)) err_nxt = sat_inc(err_cnt);
                        rcnt_nxt = rcnt + BL'(1);
                        finish   = (rcnt_nxt == app_req_len);
                        if (finish != app_last_rd) proto_nxt = 1'b1;
                    end
                    if (app_wr_next_req) proto_nxt = 1'b1;
                end
                if (finish) begin
                    state_nxt = S_DONE;
                    // Data finishing before the request was ever acknowledged.
                    if ((state == S_REQ) && !app_req_ack) proto_nxt = 1'b1;
                end else if (activity) begin
                    wdog_nxt = '0;
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                    if (wdog_nxt == WD_W'(TIMEOUT)) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = S_DONE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every output is registered from the next-state decode.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state        <= S_IDLE;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b0;
            seed         <= '0;
            wcnt         <= '0;
            rcnt         <= '0;
            wdog         <= '0;
            err_cnt      <= '0;
            proto_err    <= 1'b0;
            timeout      <= 1'b0;
            app_req      <= 1'b0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            app_wr_en_n  <= {APP_BW{1'b1}};
            app_wr_data  <= '0;
        end else begin
            state        <= state_nxt;
            app_req_addr <= addr_nxt;
            app_req_len  <= len_nxt;
            app_req_wr_n <= wr_n_nxt;
            seed         <= seed_nxt;
            wcnt         <= wcnt_nxt;
            rcnt         <= rcnt_nxt;
            wdog         <= wdog_nxt;
            err_cnt      <= err_nxt;
            proto_err    <= proto_nxt;
            timeout      <= timeout_nxt;
            app_req      <= (state_nxt == S_REQ);
            cmd_ready    <= (state_nxt == S_IDLE);
            busy         <= (state_nxt != S_IDLE);
            done         <= (state_nxt == S_DONE);
            app_wr_en_n  <= (((state_nxt == S_REQ) || (state_nxt == S_XFER)) && !wr_n_nxt)
                            ? {APP_BW{1'b0}} : {APP_BW{1'b1}};
            app_wr_data  <= seed_nxt + APP_DW'(wcnt_nxt);
        end
    end

endmodule

// File: tb/tb_sdr_app_traffic_gen.sv
// Scoreboard bench for sdr_app_traffic_gen: the bench plays sequencer and controller,
// a monitor checks every write word and every completion against a spec-level model.
module tb_sdr_app_traffic_gen;

    localparam int APP_AW = 26;
    localparam int APP_DW = 32;
    localparam int APP_BW = 4;
    localparam int BL     = 9;
    localparam int TO     = 16;

    logic              sdram_clk = 1'b0;
    logic              sdram_resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_wr_n = 1'b0;
    logic [APP_AW-1:0] cmd_addr = '0;
    logic [BL-1:0]     cmd_len = '0;
    logic [APP_DW-1:0] cmd_seed = '0;
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [BL-1:0]     app_req_len;
    logic              app_req_wr_n;
    logic              app_req_ack = 1'b0;
    logic [APP_BW-1:0] app_wr_en_n;
    logic [APP_DW-1:0] app_wr_data;
    logic              app_wr_next_req = 1'b0;
    logic              app_last_wr = 1'b0;
    logic              app_rd_valid = 1'b0;
    logic [APP_DW-1:0] app_rd_data = '0;
    logic              app_last_rd = 1'b0;
    logic              busy;
    logic              done;
    logic [15:0]       err_cnt;
    logic              proto_err;
    logic              timeout;

    sdr_app_traffic_gen #(
        .APP_AW(APP_AW), .APP_DW(APP_DW), .APP_BW(APP_BW), .BL(BL), .TIMEOUT(TO)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_n(cmd_wr_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
        .app_wr_en_n(app_wr_en_n), .app_wr_data(app_wr_data),
        .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
        .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data), .app_last_rd(app_last_rd),
        .busy(busy), .done(done), .err_cnt(err_cnt), .proto_err(proto_err), .timeout(timeout)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        logic [15:0] err;
        logic        proto;
        logic        tmo;
    } exp_t;
    typedef logic [APP_DW-1:0] word_q_t[$];
    typedef logic bit_q_t[$];

    exp_t              exp_q[$];
    logic [APP_DW-1:0] wexp_q[$];
    int                checks = 0;
    int                failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: completions and write words are compared as the DUT presents them.
    always @(negedge sdram_clk) begin : mon
        exp_t e;
        if (sdram_resetn && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                chk("done_err_cnt", 64'(err_cnt), 64'(e.err));
                chk("done_proto_err", 64'(proto_err), 64'(e.proto));
                chk("done_timeout", 64'(timeout), 64'(e.tmo));
            end
        end
        if (sdram_resetn && app_wr_next_req && (wexp_q.size() > 0)) begin
            chk("wr_data", 64'(app_wr_data), 64'(wexp_q.pop_front()));
            chk("wr_en_n", 64'(app_wr_en_n), 64'(0));
        end
    end

    // Reference: what a completed burst must report, straight from the pattern rules.
    function automatic exp_t model(input logic wr_n, input int len, input logic [APP_DW-1:0] seed,
                                   input word_q_t rdata, input bit_q_t lastf);
        exp_t e;
        int   errs = 0;
        e.proto = (len == 0);
        e.tmo   = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (wr_n && (rdata[i] != seed + APP_DW'(i))) errs++;
            if (lastf[i] != (i == len - 1)) e.proto = 1'b1;
        end
        e.err = (errs > 65535) ? 16'hFFFF : 16'(errs);
        return e;
    endfunction

    function automatic bit_q_t std_last(input int len);
        bit_q_t q;
        for (int i = 0; i < len; i++) q.push_back(i == len - 1);
        return q;
    endfunction

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 40) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    endtask

    task automatic issue(input logic wr_n, input logic [APP_AW-1:0] addr,
                         input logic [BL-1:0] len, input logic [APP_DW-1:0] seed);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_wr_n  = wr_n;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_seed  = seed;
        tick();
        cmd_valid = 1'b0;
        cmd_wr_n  = 1'($urandom);
        cmd_addr  = APP_AW'($urandom);
        cmd_len   = BL'($urandom);
        cmd_seed  = $urandom;
        chk("busy_after_accept", 64'(busy), 64'(1));
        chk("ready_after_accept", 64'(cmd_ready), 64'(0));
        if (len != 0) begin
            chk("req_rise", 64'(app_req), 64'(1));
            chk("req_addr", 64'(app_req_addr), 64'(addr));
            chk("req_len", 64'(app_req_len), 64'(len));
            chk("req_wr_n", 64'(app_req_wr_n), 64'(wr_n));
        end else begin
            chk("zero_len_no_req", 64'(app_req), 64'(0));
        end
    endtask

    task automatic do_ack(input int dly);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("req_hold", 64'(app_req), 64'(1));
        end
        app_req_ack = 1'b1;
        tick();
        app_req_ack = 1'b0;
        chk("req_drop_after_ack", 64'(app_req), 64'(0));
    endtask

    task automatic run_burst(input logic wr_n, input int len, input word_q_t rdata,
                             input bit_q_t lastf, input int max_gap);
        for (int i = 0; i < len; i++) begin
            int g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            repeat (g) tick();
            if (wr_n) begin
                app_rd_valid = 1'b1;
                app_rd_data  = rdata[i];
                app_last_rd  = lastf[i];
            end else begin
                app_wr_next_req = 1'b1;
                app_last_wr     = lastf[i];
            end
            tick();
            app_rd_valid    = 1'b0;
            app_wr_next_req = 1'b0;
            app_last_rd     = 1'b0;
            app_last_wr     = 1'b0;
        end
        chk("done_after_final", 64'(done), 64'(1));
        tick();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("ready_after_done", 64'(cmd_ready), 64'(1));
        chk("idle_not_busy", 64'(busy), 64'(0));
    endtask

    task automatic full_cmd(input logic wr_n, input int len, input logic [APP_DW-1:0] seed,
                            input word_q_t rd, input bit_q_t lf, input int ack_dly, input int gap);
        exp_q.push_back(model(wr_n, len, seed, rd, lf));
        if (!wr_n) for (int i = 0; i < len; i++) wexp_q.push_back(seed + APP_DW'(i));
        issue(wr_n, APP_AW'($urandom), BL'(len), seed);
        do_ack(ack_dly);
        run_burst(wr_n, len, rd, lf, gap);
    endtask

    task automatic rand_cmd();
        logic              wr_n = 1'($urandom);
        int                len  = $urandom_range(12, 1);
        logic [APP_DW-1:0] seed = $urandom;
        word_q_t           rd;
        bit_q_t            lf;
        lf = std_last(len);
        if ($urandom_range(5, 0) == 0) begin
            int k = $urandom_range(len - 1, 0);
            lf[k] = !lf[k];
        end
        for (int i = 0; i < len; i++)
            rd.push_back(($urandom_range(3, 0) == 0) ? $urandom : seed + APP_DW'(i));
        full_cmd(wr_n, len, seed, rd, lf, $urandom_range(3, 0), 2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        word_q_t none;
        word_q_t rd;
        bit_q_t  lf;
        exp_t    e;

        repeat (2) tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_app_req", 64'(app_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_req_addr", 64'(app_req_addr), 64'(0));
        chk("rst_req_len", 64'(app_req_len), 64'(0));
        chk("rst_req_wr_n", 64'(app_req_wr_n), 64'(0));
        chk("rst_wr_data", 64'(app_wr_data), 64'(0));
        chk("rst_wr_en_n", 64'(app_wr_en_n), 64'(4'hF));
        sdram_resetn = 1'b1;
        tick();
        chk("ready_after_release", 64'(cmd_ready), 64'(1));

        // Directed write: 0x1000..0x1003 at 0x100.
        exp_q.push_back(model(1'b0, 4, 32'h1000, none, std_last(4)));
        for (int i = 0; i < 4; i++) wexp_q.push_back(32'h1000 + APP_DW'(i));
        issue(1'b0, 26'h100, 9'd4, 32'h1000);
        do_ack(3);
        run_burst(1'b0, 4, none, std_last(4), 0);

        // Directed read with one corrupted word.
        rd = '{32'h1000, 32'h1001, 32'hDEAD, 32'h1003};
        full_cmd(1'b1, 4, 32'h1000, rd, std_last(4), 1, 0);
        chk("read_err_cnt_held", 64'(err_cnt), 64'(1));

        // Read of 8 with last_rd early on beat 6 and missing on beat 8.
        rd.delete();
        for (int i = 0; i < 8; i++) rd.push_back(32'h2000 + APP_DW'(i));
        lf = '{0, 0, 0, 0, 0, 1, 0, 0};
        full_cmd(1'b1, 8, 32'h2000, rd, lf, 0, 1);
        chk("early_last_proto_held", 64'(proto_err), 64'(1));

        // Ack never comes: watchdog fires on the 16th idle cycle.
        e.err = 16'd0; e.proto = 1'b0; e.tmo = 1'b1;
        exp_q.push_back(e);
        issue(1'b1, 26'h40, 9'd4, 32'h55);
        repeat (TO - 1) tick();
        chk("tmo_not_early", 64'(timeout), 64'(0));
        chk("tmo_req_still_up", 64'(app_req), 64'(1));
        tick();
        chk("tmo_set", 64'(timeout), 64'(1));
        chk("tmo_req_drop", 64'(app_req), 64'(0));
        chk("tmo_done", 64'(done), 64'(1));
        tick();
        chk("tmo_ready_back", 64'(cmd_ready), 64'(1));

        // Zero length: straight to DONE, then a good write clears the flags.
        e.err = 16'd0; e.proto = 1'b1; e.tmo = 1'b0;
        exp_q.push_back(e);
        issue(1'b0, 26'h80, 9'd0, 32'h77);
        chk("zl_done", 64'(done), 64'(1));
        chk("zl_timeout_cleared", 64'(timeout), 64'(0));
        tick();
        chk("zl_done_drop", 64'(done), 64'(0));
        chk("zl_no_req", 64'(app_req), 64'(0));
        exp_q.push_back(model(1'b0, 3, 32'h9000, none, std_last(3)));
        for (int i = 0; i < 3; i++) wexp_q.push_back(32'h9000 + APP_DW'(i));
        issue(1'b0, 26'h300, 9'd3, 32'h9000);
        chk("accept_clears_proto", 64'(proto_err), 64'(0));
        do_ack(0);
        run_burst(1'b0, 3, none, std_last(3), 1);

        // Reset while the request is pending: app_req falls at once.
        issue(1'b1, 26'h10, 9'd4, 32'h1);
        sdram_resetn = 1'b0;
        #2;
        chk("rst_req_pending_drop", 64'(app_req), 64'(0));
        tick();
        sdram_resetn = 1'b1;

        // Reset during a 16-word write: no done, then normal service.
        for (int i = 0; i < 16; i++) wexp_q.push_back(32'hA000 + APP_DW'(i));
        issue(1'b0, 26'h500, 9'd16, 32'hA000);
        do_ack(1);
        for (int i = 0; i < 5; i++) begin
            app_wr_next_req = 1'b1;
            tick();
            app_wr_next_req = 1'b0;
        end
        sdram_resetn = 1'b0;
        #2;
        chk("mid_rst_req", 64'(app_req), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_wr_en_n", 64'(app_wr_en_n), 64'(4'hF));
        wexp_q.delete();
        repeat (3) tick();
        chk("mid_rst_no_done", 64'(done), 64'(0));
        sdram_resetn = 1'b1;
        full_cmd(1'b0, 5, 32'hFFFF_FFFE, none, std_last(5), 2, 1);

        for (int n = 0; n < 25; n++) rand_cmd();

        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        chk("wdata_queue_empty", 64'(wexp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
